random_collector: RTL and testbench
===================================

RANDOM_COLLECTOR -- requirements
Module: random_collector

Interface
REQ-001 SHALL have parameter DECIMATE, default 8, meaning clock cycles between successive byte samples (legal 1..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning 32-bit word FIFO entries (power of two, 2..16).
REQ-003 SHALL have port i_clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port i_data  input  8  random byte stream from the random generator; new value every cycle.
REQ-006 SHALL have port i_start  input  1  one-cycle request to begin a collection.
REQ-007 SHALL have port i_count  input  4  words to collect; sampled with i_start; 0 means 16.
REQ-008 SHALL have port i_abort  input  1  cancel the collection and flush the FIFO.
REQ-009 SHALL have port o_word  output  32  head-of-FIFO word.
REQ-010 SHALL have port o_valid  output  1  o_word valid (FIFO non-empty).
REQ-011 SHALL have port i_ack  input  1  consumer pops the word when o_valid & i_ack.
REQ-012 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port o_done  output  1  one-cycle pulse at completion.

Function
REQ-014 FSM states SHALL be IDLE, COLLECT, DRAIN and DONE.
REQ-015 IDLE->COLLECT SHALL occur on i_start; start SHALL latch i_count and clear the decimation counter, byte counter and word counter.
REQ-016 i_start outside IDLE SHALL be ignored.
REQ-017 In COLLECT, the decimation counter SHALL increment each cycle and capture i_data when it equals DECIMATE-1, then wrap to 0; the first capture lands DECIMATE cycles after the start edge.
REQ-018 Byte order SHALL be big-endian: the first captured byte goes to [31:24] and the fourth to [7:0].
REQ-019 On the 4th capture, the assembled word SHALL be pushed into the FIFO in the same edge; o_valid SHALL rise the next cycle when the FIFO was empty.
REQ-020 When the FIFO is full, the decimation counter and capture SHALL hold (no sample, no loss); a pop in the same cycle as full SHALL allow that cycle's capture/push.
REQ-021 A simultaneous push and pop SHALL leave the occupancy unchanged; the FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 COLLECT->DRAIN SHALL occur on the push of the latched-count-th word.
REQ-023 DRAIN->DONE SHALL occur when the FIFO becomes empty; DONE SHALL assert o_done for one cycle, then return to IDLE.
REQ-024 i_abort in any state SHALL, on the next edge, empty the FIFO, discard the partial word, drop o_valid and enter IDLE, with no o_done; i_abort SHALL take priority over i_start and i_ack.
REQ-025 A pop SHALL be allowed in any state while o_valid is high; i_ack with o_valid low SHALL be ignored.
REQ-026 o_word SHALL be stable while o_valid is high and not acknowledged.

Reset
REQ-027 i_reset SHALL synchronously force IDLE, all counters 0, FIFO empty, o_valid=0, o_busy=0, o_done=0 and o_word=0; reset mid-collection SHALL drop all data.
REQ-028 Reset SHALL take priority over i_abort, i_start and i_ack.

Structure
REQ-029 FSM state encodings and default DECIMATE/FIFO_DEPTH values SHALL live in the shared package crypto_wallet_pkg.
REQ-030 The word FIFO SHALL be a separate sub-module sync_fifo (parameterised width and depth, push/pop/full/empty), instantiated once.

Verification
REQ-031 DECIMATE=1, i_data counting 0x00,0x01,..., i_count=1, i_ack tied high -> o_word=0x00010203 (relative to the first captured byte), single pop, o_done pulse, o_busy low afterwards.
REQ-032 Default parameters, i_count=0, i_ack low until full -> exactly 8 words queued, capture halts, then i_ack high -> 16 words total, in order, no byte skipped or duplicated across the stall.
REQ-033 i_abort asserted 3 cycles after the 2nd push -> o_valid low next cycle, no o_done, IDLE; a new i_start collects fresh words.
REQ-034 i_reset pulsed mid-COLLECT with 5 words queued -> all outputs 0 the next cycle; subsequent i_start works normally.
REQ-035 i_start re-pulsed during COLLECT, and i_ack pulsed with o_valid low -> no effect on counts, word order or FIFO occupancy.

Source files
------------

// File: rtl/crypto_wallet_pkg.sv
// Shared definitions for the random byte collector: FSM encoding and default sizing.
package crypto_wallet_pkg;

  localparam int DECIMATE_DEFAULT   = 8;
  localparam int FIFO_DEPTH_DEFAULT = 8;
  localparam int WORD_W             = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // A requested count of 0 stands for the full 16 words.
  function automatic logic [4:0] count_words(input logic [3:0] cnt);
    return (cnt == 4'd0) ? 5'd16 : {1'b0, cnt};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and flush; head word reads as zero when empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage write; contents need no reset because the output is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/random_collector.sv
// Collects decimated bytes from the random source into big-endian 32-bit words and
// queues them for a consumer.
//
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   ST_IDLE    | waiting for i_start
//   ST_COLLECT | sampling every DECIMATE cycles, pushing a word per 4 bytes
//   ST_DRAIN   | all requested words pushed, waiting for the FIFO to empty
//   ST_DONE    | one-cycle completion pulse, then back to idle
module random_collector
  import crypto_wallet_pkg::*;
#(
  parameter int DECIMATE   = DECIMATE_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_data,
  input  logic              i_start,
  input  logic [3:0]        i_count,
  input  logic              i_abort,
  output logic [WORD_W-1:0] o_word,
  output logic              o_valid,
  input  logic              i_ack,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [7:0] DEC_LAST = 8'(DECIMATE - 1);

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        decim_cnt;
  logic [1:0]        byte_cnt;
  logic [4:0]        word_cnt;
  logic [4:0]        word_target;
  logic [23:0]       partial;
  logic [WORD_W-1:0] push_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              advance;
  logic              capture;
  logic              push;
  logic              last_push;

  assign pop       = ~fifo_empty & i_ack & ~i_abort;
  // While the FIFO is full the sampler freezes, unless the consumer frees a slot this cycle.
  assign advance   = (state == ST_COLLECT) & (~fifo_full | pop) & ~i_abort;
  assign capture   = advance & (decim_cnt == DEC_LAST);
  assign push      = capture & (byte_cnt == 2'd3);
  assign last_push = push & ((word_cnt + 5'd1) == word_target);
  assign push_word = {partial, i_data};
  assign o_valid   = ~fifo_empty;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .reset (i_reset),
    .flush (i_abort),
    .push  (push),
    .pop   (pop),
    .din   (push_word),
    .dout  (o_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (i_start)    state_nxt = ST_COLLECT;
      ST_COLLECT: if (last_push)  state_nxt = ST_DRAIN;
      ST_DRAIN:   if (fifo_empty) state_nxt = ST_DONE;
      ST_DONE:                    state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
    if (i_abort) state_nxt = ST_IDLE;
  end

  // Status outputs decoded from the state.
  always_comb begin
    o_busy = (state != ST_IDLE);
    o_done = (state == ST_DONE);
  end

  // Sampling counters and byte assembly.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_abort) begin
      decim_cnt   <= '0;
      byte_cnt    <= '0;
      word_cnt    <= '0;
      word_target <= '0;
      partial     <= '0;
    end else if (state == ST_IDLE && i_start) begin
      decim_cnt   <= '0;
      byte_cnt    <= '0;
      word_cnt    <= '0;
      word_target <= count_words(i_count);
      partial     <= '0;
    end else if (advance) begin
      if (capture) begin
        decim_cnt <= '0;
        byte_cnt  <= byte_cnt + 2'd1;
        partial   <= {partial[15:0], i_data};
        if (push) word_cnt <= word_cnt + 5'd1;
      end else begin
        decim_cnt <= decim_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_random_collector.sv
// Randomized bench for random_collector: two instances (DECIMATE=1/depth 4 and defaults)
// compared every cycle against a transaction-level model of the byte sampler and word queue.
`timescale 1ns/1ps
module tb_random_collector;

  localparam int DEC_A = 1;
  localparam int DEP_A = 4;
  localparam int DEC_B = 8;
  localparam int DEP_B = 8;

  logic        clk = 1'b0;
  logic [7:0]  data;
  logic        rst   [2];
  logic        start [2];
  logic        abort [2];
  logic        ack   [2];
  logic [3:0]  cnt   [2];
  logic [31:0] word  [2];
  logic        valid [2];
  logic        busy  [2];
  logic        done  [2];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;
  bit cnt_mode = 0;

  always #5 clk = ~clk;

  random_collector #(.DECIMATE(DEC_A), .FIFO_DEPTH(DEP_A)) u_a (
    .i_clk(clk), .i_reset(rst[0]), .i_data(data), .i_start(start[0]), .i_count(cnt[0]),
    .i_abort(abort[0]), .o_word(word[0]), .o_valid(valid[0]), .i_ack(ack[0]),
    .o_busy(busy[0]), .o_done(done[0]));

  random_collector #(.DECIMATE(DEC_B), .FIFO_DEPTH(DEP_B)) u_b (
    .i_clk(clk), .i_reset(rst[1]), .i_data(data), .i_start(start[1]), .i_count(cnt[1]),
    .i_abort(abort[1]), .o_word(word[1]), .o_valid(valid[1]), .i_ack(ack[1]),
    .o_busy(busy[1]), .o_done(done[1]));

  // ---------------- reference model ----------------
  logic [31:0] m_q [2][16];
  int          m_head [2];
  int          m_cnt  [2];
  int          m_adv  [2];
  int          m_nb   [2];
  int          m_words[2];
  int          m_target[2];
  logic [31:0] m_acc  [2];
  bit          m_coll [2];
  bit          m_drain[2];
  bit          m_done [2];

  function automatic int dec_of(input int k);
    return (k == 0) ? DEC_A : DEC_B;
  endfunction

  function automatic int dep_of(input int k);
    return (k == 0) ? DEP_A : DEP_B;
  endfunction

  task automatic model_clear(input int k);
    m_head[k] = 0; m_cnt[k] = 0; m_adv[k] = 0; m_nb[k] = 0;
    m_words[k] = 0; m_target[k] = 0; m_acc[k] = '0;
    m_coll[k] = 0; m_drain[k] = 0; m_done[k] = 0;
  endtask

  task automatic model_step(input int k);
    bit do_pop;
    bit idle;
    bit adv_ok;
    int pre_cnt;
    if (rst[k] || abort[k]) begin
      model_clear(k);
      return;
    end
    pre_cnt = m_cnt[k];
    do_pop  = (pre_cnt > 0) && ack[k];
    idle    = !m_coll[k] && !m_drain[k] && !m_done[k];
    adv_ok  = m_coll[k] && ((pre_cnt < dep_of(k)) || do_pop);
    if (m_done[k]) m_done[k] = 0;
    else if (m_drain[k] && pre_cnt == 0) begin
      m_drain[k] = 0;
      m_done[k]  = 1;
    end
    if (do_pop) begin
      m_head[k] = (m_head[k] + 1) % 16;
      m_cnt[k]  = m_cnt[k] - 1;
    end
    if (adv_ok) begin
      m_adv[k] = m_adv[k] + 1;
      if (m_adv[k] % dec_of(k) == 0) begin
        m_acc[k] = {m_acc[k][23:0], data};
        m_nb[k]  = m_nb[k] + 1;
        if (m_nb[k] == 4) begin
          m_nb[k] = 0;
          m_q[k][(m_head[k] + m_cnt[k]) % 16] = m_acc[k];
          m_cnt[k]   = m_cnt[k] + 1;
          m_words[k] = m_words[k] + 1;
          if (m_words[k] == m_target[k]) begin
            m_coll[k]  = 0;
            m_drain[k] = 1;
          end
        end
      end
    end
    if (idle && start[k]) begin
      m_coll[k]   = 1;
      m_adv[k]    = 0;
      m_nb[k]     = 0;
      m_words[k]  = 0;
      m_target[k] = (cnt[k] == 4'd0) ? 16 : int'(cnt[k]);
    end
  endtask

  function automatic logic [31:0] exp_word(input int k);
    return (m_cnt[k] > 0) ? m_q[k][m_head[k]] : 32'd0;
  endfunction

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check_val($sformatf("word%0d", k), word[k], exp_word(k));
        check_val($sformatf("flags%0d", k), {29'd0, valid[k], busy[k], done[k]},
                  {29'd0, m_cnt[k] > 0, m_coll[k] | m_drain[k] | m_done[k], m_done[k]});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    data = cnt_mode ? data + 8'd1 : 8'($urandom);
  endtask

  task automatic wait_done(input int k, input int budget, input string tag);
    int n;
    n = 0;
    while (!done[k] && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, {31'd0, done[k]}, 32'd1);
  endtask

  initial begin
    logic [7:0] s;
    int n;
    int pops;
    int dcount;
    bit got;

    data = 8'd0;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; abort[k] = 1'b0; ack[k] = 1'b0; cnt[k] = 4'd0;
    end
    repeat (3) tick();
    chk_en = 1;
    check_val("reset_word", word[1], 32'd0);
    check_val("reset_flags", {29'd0, valid[1], busy[1], done[1]}, 32'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick();

    // Single word at DECIMATE=1 with a counting byte stream.
    cnt_mode = 1;
    tick();
    s = data;
    start[0] = 1'b1; cnt[0] = 4'd1; ack[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n = 0;
    while (!valid[0] && n < 20) begin
      tick();
      n++;
    end
    check_val("s1_word", word[0], {s + 8'd1, s + 8'd2, s + 8'd3, s + 8'd4});
    dcount = 0;
    repeat (20) begin
      tick();
      if (done[0]) dcount++;
    end
    check_val("s1_done_pulses", 32'(dcount), 32'd1);
    check_val("s1_busy_after", {31'd0, busy[0]}, 32'd0);
    ack[0] = 1'b0;
    cnt_mode = 0;

    // Sixteen words with the consumer stalled until the FIFO fills.
    start[1] = 1'b1; cnt[1] = 4'd0; ack[1] = 1'b0;
    tick();
    start[1] = 1'b0;
    n = 0;
    while (!(valid[1] && m_cnt[1] == DEP_B) && n < 400) begin
      tick();
      n++;
    end
    repeat (64) tick();
    check_val("s2_stalled_busy", {31'd0, busy[1]}, 32'd1);
    ack[1] = 1'b1;
    pops = 0;
    got = 0;
    n = 0;
    while (!got && n < 700) begin
      if (valid[1]) pops++;
      tick();
      if (done[1]) got = 1;
      n++;
    end
    check_val("s2_pops", 32'(pops), 32'd16);
    check_val("s2_done", {31'd0, got}, 32'd1);
    ack[1] = 1'b0;
    repeat (2) tick();

    // Abort a few cycles after the second push, then collect fresh words.
    start[1] = 1'b1; cnt[1] = 4'd4;
    tick();
    start[1] = 1'b0;
    n = 0;
    while (m_words[1] < 2 && n < 200) begin
      tick();
      n++;
    end
    repeat (2) tick();
    abort[1] = 1'b1;
    tick();
    abort[1] = 1'b0;
    check_val("s3_abort_flags", {29'd0, valid[1], busy[1], done[1]}, 32'd0);
    start[1] = 1'b1; cnt[1] = 4'd2; ack[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    wait_done(1, 200, "s3_restart_done");
    ack[1] = 1'b0;
    repeat (2) tick();

    // Reset mid-collection with five words queued.
    start[1] = 1'b1; cnt[1] = 4'd0;
    tick();
    start[1] = 1'b0;
    n = 0;
    while (m_cnt[1] < 5 && n < 300) begin
      tick();
      n++;
    end
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    check_val("s4_reset_word", word[1], 32'd0);
    check_val("s4_reset_flags", {29'd0, valid[1], busy[1], done[1]}, 32'd0);
    start[1] = 1'b1; cnt[1] = 4'd3; ack[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    wait_done(1, 300, "s4_restart_done");
    ack[1] = 1'b0;
    repeat (2) tick();

    // Stray starts during collection and acks while nothing is valid.
    start[1] = 1'b1; cnt[1] = 4'd3;
    tick();
    for (int i = 0; i < 150; i++) begin
      start[1] = (i % 10 == 5);
      cnt[1]   = 4'd7;
      ack[1]   = !valid[1] && (i % 3 == 0);
      tick();
    end
    start[1] = 1'b0;
    ack[1] = 1'b1;
    pops = 0;
    got = 0;
    n = 0;
    while (!got && n < 100) begin
      if (valid[1]) pops++;
      tick();
      if (done[1]) got = 1;
      n++;
    end
    check_val("s5_pops", 32'(pops), 32'd3);
    check_val("s5_done", {31'd0, got}, 32'd1);

    // Random traffic on both instances.
    for (int i = 0; i < 2500; i++) begin
      for (int k = 0; k < 2; k++) begin
        start[k] = ($urandom_range(0, 19) == 0);
        cnt[k]   = 4'($urandom);
        ack[k]   = ($urandom_range(0, 2) != 0);
        abort[k] = ($urandom_range(0, 199) == 0);
        rst[k]   = ($urandom_range(0, 599) == 0);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; abort[k] = 1'b0; rst[k] = 1'b0; ack[k] = 1'b1;
    end
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
